// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package imem_loader_pkg;

  localparam int LEN_W          = 16;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_FLUSH  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  // A length is rejected when it asks for more words than the memory holds.
  function automatic logic len_exceeds_depth(input logic [LEN_W-1:0] len, input int addr_w);
    return ({1'b0, len} > ((LEN_W+1)'(1) << addr_w));
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  // The loader: consumes the stream, drives the memory write port.
  modport master (
    input  s_data, s_valid,
    output s_ready, wr_en, wr_addr, wr_data
  );

  // The environment: produces the stream, observes the writes.
  modport slave (
    output s_data, s_valid,
    input  s_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs four accepted stream bytes into one 32-bit instruction word.
module imem_loader_word_assembler
  import imem_loader_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        take,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [31:0] shift_q;
  logic [1:0]  byte_idx;

  // Byte position within the current word; restarts at the head of every image.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   byte_idx <= '0;
    else if (clear) byte_idx <= '0;
    else if (take)  byte_idx <= byte_idx + 2'd1;
  end

  // Assembly register holds the bytes already taken for this word.
  always_ff @(posedge clk) begin
    if (take) shift_q <= word;
  end

  // The word including the byte being taken now, so it is complete on the 4th byte.
  always_comb begin
    word       = BIG_ENDIAN ? {shift_q[23:0], byte_in} : {byte_in, shift_q[31:8]};
    word_valid = take && (byte_idx == 2'(BYTES_PER_WORD - 1));
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: length-prefixed byte stream -> sequential instruction-memory writes,
// holding the core stalled until the whole image is in memory.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          cpu_run,
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_t            state, state_nx;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  len_full;
  logic [ADDR_W:0]   word_ptr;
  logic              xfer;
  logic              word_valid;
  logic              last_word;
  logic [31:0]       word;

  assign xfer      = bus.s_valid && bus.s_ready;
  assign len_full  = {len_q[LEN_W-1:8], bus.s_data};
  assign last_word = (LEN_W'(word_ptr) == (len_q - LEN_W'(1)));

  assign bus.s_ready = (state == ST_LEN_HI) || (state == ST_LEN_LO) || (state == ST_DATA);
  assign busy        = bus.s_ready || (state == ST_FLUSH);
  assign done        = (state == ST_DONE);
  assign cpu_run     = (state == ST_DONE);
  assign err         = (state == ST_ERROR);

  imem_loader_word_assembler #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_asm (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     ((state == ST_LEN_LO) && xfer),
    .take      ((state == ST_DATA) && xfer),
    .byte_in   (bus.s_data),
    .word_valid(word_valid),
    .word      (word)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // Next-state logic; s_ready is high in every state that looks at s_valid.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (start) state_nx = ST_LEN_HI;
      ST_LEN_HI: if (bus.s_valid) state_nx = ST_LEN_LO;
      ST_LEN_LO: begin
        if (bus.s_valid) begin
          if (len_full == '0)                            state_nx = ST_DONE;
          else if (len_exceeds_depth(len_full, ADDR_W))  state_nx = ST_ERROR;
          else                                           state_nx = ST_DATA;
        end
      end
      ST_DATA:   if (word_valid && last_word) state_nx = ST_FLUSH;
      ST_FLUSH:  state_nx = ST_DONE;
      ST_DONE:   if (start) state_nx = ST_LEN_HI;
      ST_ERROR:  if (start) state_nx = ST_LEN_HI;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Length capture, word pointer and the registered memory write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q       <= '0;
      word_ptr    <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else begin
      bus.wr_en <= word_valid;
      if ((state == ST_LEN_HI) && xfer) len_q[LEN_W-1:8] <= bus.s_data;
      if ((state == ST_LEN_LO) && xfer) begin
        len_q[7:0] <= bus.s_data;
        word_ptr   <= '0;
      end
      if (word_valid) begin
        bus.wr_addr <= word_ptr[ADDR_W-1:0];
        bus.wr_data <= word;
        word_ptr    <= word_ptr + 1'b1;
      end
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory writer for the single-cycle MIPS core. It accepts a length-prefixed byte stream over a valid/ready interface and assembles the bytes into 32-bit instruction words. It writes those words sequentially from word address 0 into the instruction memory's write port. It holds the core stalled (`cpu_run` low) until a complete image has been written.

## Interface
- `ADDR_W`, default 8: instruction-memory word-address width; DEPTH = 2^ADDR_W words.
- `BIG_ENDIAN`, default 1: 1 = first byte of each word goes to [31:24]; 0 = first byte goes to [7:0].

- `clk` in 1: single clock, rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that arms a load; ignored in LEN_HI, LEN_LO, DATA and FLUSH.
- `s_data` in 8: stream byte.
- `s_valid` in 1: `s_data` is valid.
- `s_ready` out 1: loader accepts a byte; a transfer occurs at a rising edge with `s_valid && s_ready`.
- `wr_en` out 1: one-cycle instruction-memory write strobe.
- `wr_addr` out ADDR_W: word address of the write.
- `wr_data` out 32: assembled instruction word.
- `cpu_run` out 1: core enable; gates PC advance and RegWrite/MemWrite.
- `busy` out 1: a load is in progress.
- `done` out 1: the last load completed.
- `err` out 1: the last length field was rejected.

## Operation
- Stream format: LEN_HI, LEN_LO (16-bit word count N, big-endian regardless of `BIG_ENDIAN`), then 4·N data bytes.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, FLUSH, DONE, ERROR.
  - IDLE: `start` → LEN_HI; clears `done` and `err`.
  - LEN_HI: on transfer, len[15:8] ← byte; → LEN_LO.
  - LEN_LO: on transfer, len[7:0] ← byte, then:
    - N == 0 → DONE;
    - N > DEPTH → ERROR;
    - otherwise → DATA, with byte_idx = 0 and word_ptr = 0.
  - DATA: each transfer shifts the byte into the assembly register per `BIG_ENDIAN` and increments byte_idx (2 bits, wraps 3→0).
    - On the 4th byte: the next cycle has `wr_en` = 1, `wr_addr` = word_ptr, `wr_data` = assembled word; word_ptr then increments.
    - On the 4th byte of word N-1 → FLUSH; otherwise stay in DATA.
  - FLUSH: `wr_en` high for the final word; → DONE.
  - DONE: `done` = 1, `cpu_run` = 1; `start` → LEN_HI, which drops `cpu_run` and `done` on the next cycle.
  - ERROR: `err` = 1, `cpu_run` = 0; `start` → LEN_HI, which clears `err`.
- Output decode:
  - `s_ready` = 1 only in LEN_HI, LEN_LO and DATA.
  - `busy` = 1 in LEN_HI, LEN_LO, DATA and FLUSH.
- word_ptr is ADDR_W+1 bits. Because N ≤ DEPTH is enforced, `wr_addr` never wraps.
- The assembly register is separate from the `wr_data` register, so a byte of the next word is accepted in the same cycle `wr_en` is high.
- Memory contents are never cleared; only words 0..N-1 are written.

## Timing
- Reset value of every output is 0. `reset_n` low forces the outputs to 0 and the FSM to IDLE immediately, with no clock edge required. This also applies mid-load; the partial image is left in memory.
- Write latency: `wr_en` is high in the cycle after the edge that accepted the 4th byte, for exactly one cycle.
- `done` and `cpu_run` rise one cycle after the final `wr_en` cycle, so the memory write commits before the core's first fetch.
- Idle cycles with `s_valid` low stall the FSM with no state change. Throughput is one byte per cycle.
- `start` coinciding with reset deassertion is ignored if `reset_n` is still low at that edge.

## Structure
- A shared defines package holds:
  - FSM state encoding (3 bits);
  - LEN_W = 16;
  - the byte-per-word constant 4.
- One sub-module is natural: `word_assembler`. It takes the byte-shift register, byte_idx and the endianness mux, and outputs `word_valid` and `word`.
- The FSM, length/pointer counters and output registers live in `imem_loader`.

## Test plan
- `start`, stream 00 02 20 08 00 05 00 00 00 00, continuous `s_valid` → two writes: addr 0 / 0x20080005, then addr 1 / 0x00000000. `done` and `cpu_run` rise exactly one cycle after the second `wr_en`.
- Stream 00 00 → no `wr_en`; DONE is entered on the cycle after LEN_LO; `cpu_run` = 1.
- With ADDR_W = 8, stream 01 01 → ERROR; `err` = 1, `s_ready` = 0, no writes, `cpu_run` = 0. A subsequent `start` clears `err` one cycle later.
- BIG_ENDIAN = 0, stream 00 01 05 00 08 20, with `s_valid` toggled randomly ~50% → a single write: addr 0 / 0x20080005; no byte dropped or duplicated.
- Pull `reset_n` low after 6 data bytes of an N = 3 load → all outputs go to 0 asynchronously, FSM in IDLE. A new `start` with N = 1 writes addr 0 correctly.
- `start` pulsed mid-DATA → ignored, and the load completes normally. `start` in DONE → `cpu_run` falls the next cycle and the loader accepts a new length.
